// File: rtl/sc_game_pkg.sv
// Shared game definitions: FSM state encodings and counter defaults used by the
// lives/levels counter and the general game state machine.
package sc_game_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOCK_LOSE = 2'd1,
    ST_LOCK_WIN  = 2'd2
  } gameState_t;

  localparam int INIT_LIVES_DEF = 3;
  localparam int MAX_LEVELS_DEF = 4;
  localparam int CNT_W_DEF      = 3;

endpackage

// File: rtl/sc_edge_detect_low.sv
// Falling-edge detector for an active-low strobe: one history flop (reset/clear to 1)
// and a combinational pulse when history is high and the current sample is low.
module sc_edge_detect_low (
  input  logic SC_EDGEDETECT_CLOCK_50,
  input  logic SC_EDGEDETECT_RESET_InLow,
  input  logic SC_EDGEDETECT_clear_InLow,
  input  logic SC_EDGEDETECT_strobe_InLow,
  output logic SC_EDGEDETECT_fall_Out
);

  logic historyReg;

  always_ff @(posedge SC_EDGEDETECT_CLOCK_50 or negedge SC_EDGEDETECT_RESET_InLow) begin
    if (!SC_EDGEDETECT_RESET_InLow)
      historyReg <= 1'b1;
    else if (!SC_EDGEDETECT_clear_InLow)
      historyReg <= 1'b1;
    else
      historyReg <= SC_EDGEDETECT_strobe_InLow;
  end

  assign SC_EDGEDETECT_fall_Out = historyReg & ~SC_EDGEDETECT_strobe_InLow;

endmodule

// File: rtl/sc_lives_levels_counter.sv
// Lives/levels counter answering the game state machine's count strobes.
// Optional macro SC_LIVESLEVELS_BONUS_LIFE_EN: a passed level also restores one life.
//
// state        | meaning
// ST_RUN       | counting life/level events
// ST_LOCK_LOSE | lives exhausted, counts frozen until clear/reset
// ST_LOCK_WIN  | final level reached, counts frozen until clear/reset
module sc_lives_levels_counter
  import sc_game_pkg::*;
#(
  parameter int INIT_LIVES = INIT_LIVES_DEF,
  parameter int MAX_LEVELS = MAX_LEVELS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             SC_LIVESLEVELS_CLOCK_50,
  input  logic             SC_LIVESLEVELS_RESET_InLow,
  input  logic             SC_LIVESLEVELS_clear_InLow,
  input  logic             SC_LIVESLEVELS_contador_vidas_InLow,
  input  logic             SC_LIVESLEVELS_contador_niveles_InLow,
  output logic             SC_LIVESLEVELS_COMPARATOR_LIVES_Out,
  output logic             SC_LIVESLEVELS_COMPARATOR_LEVELS_OutLow,
  output logic [CNT_W-1:0] SC_LIVESLEVELS_lives_Out,
  output logic [CNT_W-1:0] SC_LIVESLEVELS_level_Out,
  output logic             SC_LIVESLEVELS_locked_Out
);

  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_LEVELS);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  gameState_t       stateReg, stateNext;
  logic [CNT_W-1:0] livesReg, livesNext;
  logic [CNT_W-1:0] levelReg, levelNext;
  logic             lifeEvent, levelEvent;

  sc_edge_detect_low uLifeEdge (
    .SC_EDGEDETECT_CLOCK_50     (SC_LIVESLEVELS_CLOCK_50),
    .SC_EDGEDETECT_RESET_InLow  (SC_LIVESLEVELS_RESET_InLow),
    .SC_EDGEDETECT_clear_InLow  (SC_LIVESLEVELS_clear_InLow),
    .SC_EDGEDETECT_strobe_InLow (SC_LIVESLEVELS_contador_vidas_InLow),
    .SC_EDGEDETECT_fall_Out     (lifeEvent)
  );

  sc_edge_detect_low uLevelEdge (
    .SC_EDGEDETECT_CLOCK_50     (SC_LIVESLEVELS_CLOCK_50),
    .SC_EDGEDETECT_RESET_InLow  (SC_LIVESLEVELS_RESET_InLow),
    .SC_EDGEDETECT_clear_InLow  (SC_LIVESLEVELS_clear_InLow),
    .SC_EDGEDETECT_strobe_InLow (SC_LIVESLEVELS_contador_niveles_InLow),
    .SC_EDGEDETECT_fall_Out     (levelEvent)
  );

  always_ff @(posedge SC_LIVESLEVELS_CLOCK_50 or negedge SC_LIVESLEVELS_RESET_InLow) begin
    if (!SC_LIVESLEVELS_RESET_InLow) begin
      stateReg <= ST_RUN;
      livesReg <= INIT_C;
      levelReg <= '0;
    end else begin
      stateReg <= stateNext;
      livesReg <= livesNext;
      levelReg <= levelNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    livesNext = livesReg;
    levelNext = levelReg;
    if (!SC_LIVESLEVELS_clear_InLow) begin
      stateNext = ST_RUN;
      livesNext = INIT_C;
      levelNext = '0;
    end else begin
      case (stateReg)
        ST_RUN: begin
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
          // A simultaneous loss and bonus cancel out.
          if (lifeEvent && !levelEvent && livesReg != '0)
            livesNext = livesReg - ONE_C;
          else if (levelEvent && !lifeEvent && livesReg < INIT_C)
            livesNext = livesReg + ONE_C;
`else
          if (lifeEvent && livesReg != '0)
            livesNext = livesReg - ONE_C;
`endif
          if (levelEvent && levelReg < MAX_C)
            levelNext = levelReg + ONE_C;
          if (livesNext == '0)
            stateNext = ST_LOCK_LOSE;
          else if (levelNext == MAX_C)
            stateNext = ST_LOCK_WIN;
        end
        ST_LOCK_LOSE, ST_LOCK_WIN: stateNext = stateReg;
        default: stateNext = ST_RUN;
      endcase
    end
  end

  assign SC_LIVESLEVELS_COMPARATOR_LIVES_Out     = (livesReg == '0);
  assign SC_LIVESLEVELS_COMPARATOR_LEVELS_OutLow = (levelReg != MAX_C);
  assign SC_LIVESLEVELS_lives_Out                = livesReg;
  assign SC_LIVESLEVELS_level_Out                = levelReg;
  assign SC_LIVESLEVELS_locked_Out               = (stateReg != ST_RUN);

endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Self-checking bench for sc_lives_levels_counter against a behavioural game model;
// honours SC_LIVESLEVELS_BONUS_LIFE_EN when defined.
module tb_sc_lives_levels_counter;

  localparam int INIT_L = 3;
  localparam int MAX_L  = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       clrN = 1'b1;
  logic       lifeN = 1'b1;
  logic       levN = 1'b1;
  logic       cmpLives, cmpLevelsN, locked;
  logic [2:0] lives, level;

  int total = 0;
  int bad = 0;

  // Model: remaining lives, level, whether the game is over, last sampled strobe values
  int mLives, mLevel;
  bit mOver;
  bit mPrevLife, mPrevLev;

  sc_lives_levels_counter dut (
    .SC_LIVESLEVELS_CLOCK_50               (clk),
    .SC_LIVESLEVELS_RESET_InLow            (rstN),
    .SC_LIVESLEVELS_clear_InLow            (clrN),
    .SC_LIVESLEVELS_contador_vidas_InLow   (lifeN),
    .SC_LIVESLEVELS_contador_niveles_InLow (levN),
    .SC_LIVESLEVELS_COMPARATOR_LIVES_Out   (cmpLives),
    .SC_LIVESLEVELS_COMPARATOR_LEVELS_OutLow(cmpLevelsN),
    .SC_LIVESLEVELS_lives_Out              (lives),
    .SC_LIVESLEVELS_level_Out              (level),
    .SC_LIVESLEVELS_locked_Out             (locked)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    mLives = INIT_L; mLevel = 0; mOver = 0; mPrevLife = 1; mPrevLev = 1;
  endtask

  task automatic model_clock(input bit l, input bit v, input bit c);
    bit lifeHit, levHit;
    lifeHit = mPrevLife && !l;
    levHit  = mPrevLev && !v;
    if (!c) begin
      model_reset();
      return;
    end
    mPrevLife = l; mPrevLev = v;
    if (mOver) return;
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
    mLives = mLives - (lifeHit ? 1 : 0) + (levHit ? 1 : 0);
    if (mLives > INIT_L) mLives = INIT_L;
`else
    if (lifeHit) mLives = mLives - 1;
`endif
    if (mLives < 0) mLives = 0;
    if (levHit && mLevel < MAX_L) mLevel = mLevel + 1;
    if (mLives == 0 || mLevel == MAX_L) mOver = 1;
  endtask

  task automatic step(input bit l, input bit v, input bit c);
    @(negedge clk);
    lifeN = l; levN = v; clrN = c;
    @(posedge clk);
    model_clock(l, v, c);
    #1;
  endtask

  task automatic pulse(input bit isLife);
    step(isLife ? 1'b0 : 1'b1, isLife ? 1'b1 : 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0; lifeN = 1'b1; levN = 1'b1; clrN = 1'b1;
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL reset_lives got=%0d want=3", lives); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (cmpLives !== 1'b0) begin bad++; $display("FAIL reset_cmp_lives got=%0b want=0", cmpLives); end
    total++; if (cmpLevelsN !== 1'b1) begin bad++; $display("FAIL reset_cmp_levels got=%0b want=1", cmpLevelsN); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
  endtask

  task automatic test_hold_low();
    do_reset();
    step(1'b0, 1'b1, 1'b1);
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL hold_first_edge got=%0d want=2", lives); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL hold_once got=%0d want=2", lives); end
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_lose();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1);
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL lose_lives got=%0d want=0", lives); end
    total++; if (cmpLives !== 1'b1) begin bad++; $display("FAIL lose_cmp got=%0b want=1", cmpLives); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lose_locked got=%0b want=1", locked); end
    pulse(1'b0);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL lose_frozen_level got=%0d want=0", level); end
  endtask

  task automatic test_win_clear();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b0);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL win_level got=%0d want=4", level); end
    total++; if (cmpLevelsN !== 1'b0) begin bad++; $display("FAIL win_cmp got=%0b want=0", cmpLevelsN); end
    total++; if (locked !== 1'b1 || cmpLives !== 1'b0) begin bad++; $display("FAIL win_state got=%0b%0b want=10", locked, cmpLives); end
    pulse(1'b1);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL win_frozen_lives got=%0d want=3", lives); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    total++; if (lives !== 3'd3 || level !== 3'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL clear_exit got=%0d/%0d/%0b want=3/0/0", lives, level, locked);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b0);
    for (int i = 0; i < 2; i++) pulse(1'b1);
    total++; if (lives !== 3'd1 || level !== 3'd3) begin
      bad++; $display("FAIL sim_setup got=%0d/%0d want=1/3", lives, level);
    end
    step(1'b0, 1'b0, 1'b1);
    total++; if (lives !== 3'(mLives) || level !== 3'd4 || locked !== 1'b1) begin
      bad++; $display("FAIL sim_both got=%0d/%0d/%0b want=%0d/4/1", lives, level, locked, mLives);
    end
`ifndef SC_LIVESLEVELS_BONUS_LIFE_EN
    total++; if (cmpLives !== 1'b1) begin bad++; $display("FAIL sim_lose_priority got=%0b want=1", cmpLives); end
`endif
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_clear_priority();
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    total++; if (lives !== 3'd3 || level !== 3'd0) begin
      bad++; $display("FAIL clear_priority got=%0d/%0d want=3/0", lives, level);
    end
    step(1'b0, 1'b0, 1'b1);
    total++; if (lives !== 3'(mLives) || level !== 3'd1) begin
      bad++; $display("FAIL post_clear_edge got=%0d/%0d want=%0d/1", lives, level, mLives);
    end
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(1'b1); pulse(1'b1);
    total++; if (lives !== 3'd1) begin bad++; $display("FAIL async_setup got=%0d want=1", lives); end
    #4 rstN = 1'b0;
    #1;
    total++; if (lives !== 3'd3 || level !== 3'd0) begin
      bad++; $display("FAIL async_reset got=%0d/%0d want=3/0", lives, level);
    end
    model_reset();
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bonus();
    do_reset();
    pulse(1'b1);
    pulse(1'b0);
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
    total++; if (lives !== 3'd3 || level !== 3'd1) begin
      bad++; $display("FAIL bonus got=%0d/%0d want=3/1", lives, level);
    end
`else
    total++; if (lives !== 3'd2 || level !== 3'd1) begin
      bad++; $display("FAIL no_bonus got=%0d/%0d want=2/1", lives, level);
    end
`endif
  endtask

  task automatic test_random();
    int expLocked;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 24) != 0);
      expLocked = mOver ? 1 : 0;
      total++;
      if (lives !== 3'(mLives) || level !== 3'(mLevel) || locked !== expLocked[0] ||
          cmpLives !== (mLives == 0) || cmpLevelsN !== (mLevel != MAX_L)) begin
        bad++;
        $display("FAIL random[%0d] got=%0d/%0d/%0b/%0b/%0b want=%0d/%0d/%0d", i,
                 lives, level, locked, cmpLives, cmpLevelsN, mLives, mLevel, expLocked);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_hold_low();
    test_lose();
    test_win_clear();
    test_simultaneous();
    test_clear_priority();
    test_async_reset();
    test_bonus();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
